// File: rtl/id_exe_ctrl.sv
// id_exe_ctrl: decode-side producer of the ALU command interface.
// Decodes an ARM data-processing / memory / branch instruction into a 4-bit
// ALU command plus stage control bits. The instruction is gated on its
// condition field against the internal NZCV register. The result is captured
// into the ID/EXE pipeline register, with flush, freeze and bubble support.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   instr, pc_in             instruction in ID and its PC
//   val_rn, val_rm           register-file read data
//   hazard / freeze / flush  bubble / hold / kill controls for ID/EXE
//   status_wr, flags_in      NZCV update from EXE
//   exe_cmd, mem_r, mem_w, wb_en, s_bit, b_en, imm    registered control
//   dest, shift_op, simm24   registered instruction fields
//   pc_out, val_rn_o, val_rm_o  registered pass-through data
//   status                   current NZCV register
//   two_src                  combinational: instruction reads Rm
module id_exe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [31:0] pc_in,
  input  logic [31:0] val_rn,
  input  logic [31:0] val_rm,
  input  logic        hazard,
  input  logic        freeze,
  input  logic        flush,
  input  logic        status_wr,
  input  logic [3:0]  flags_in,
  output logic [3:0]  exe_cmd,
  output logic        mem_r,
  output logic        mem_w,
  output logic        wb_en,
  output logic        s_bit,
  output logic        b_en,
  output logic        imm,
  output logic [3:0]  dest,
  output logic [11:0] shift_op,
  output logic [23:0] simm24,
  output logic [31:0] pc_out,
  output logic [31:0] val_rn_o,
  output logic [31:0] val_rm_o,
  output logic [3:0]  status,
  output logic        two_src
);

  // Instruction fields
  logic [3:0] w_cond;
  logic [1:0] w_mode;
  logic       w_i;
  logic [3:0] w_opcode;
  logic       w_s;

  assign w_cond   = instr[31:28];
  assign w_mode   = instr[27:26];
  assign w_i      = instr[25];
  assign w_opcode = instr[24:21];
  assign w_s      = instr[20];

  // Registered state
  logic [3:0]  r_status;
  logic [3:0]  r_exe_cmd;
  logic        r_mem_r;
  logic        r_mem_w;
  logic        r_wb_en;
  logic        r_s_bit;
  logic        r_b_en;
  logic        r_imm;
  logic [3:0]  r_dest;
  logic [11:0] r_shift_op;
  logic [23:0] r_simm24;
  logic [31:0] r_pc;
  logic [31:0] r_val_rn;
  logic [31:0] r_val_rm;

  // Condition evaluation against the registered flags, so a flag update
  // landing on the same edge is only seen by the next instruction.
  logic w_n, w_z, w_c, w_v;
  logic w_cond_pass;

  assign {w_n, w_z, w_c, w_v} = r_status;

  always_comb begin
    w_cond_pass = 1'b0;
    unique case (w_cond)
      4'h0: w_cond_pass = w_z;
      4'h1: w_cond_pass = ~w_z;
      4'h2: w_cond_pass = w_c;
      4'h3: w_cond_pass = ~w_c;
      4'h4: w_cond_pass = w_n;
      4'h5: w_cond_pass = ~w_n;
      4'h6: w_cond_pass = w_v;
      4'h7: w_cond_pass = ~w_v;
      4'h8: w_cond_pass = w_c & ~w_z;
      4'h9: w_cond_pass = ~w_c | w_z;
      4'hA: w_cond_pass = (w_n == w_v);
      4'hB: w_cond_pass = (w_n != w_v);
      4'hC: w_cond_pass = ~w_z & (w_n == w_v);
      4'hD: w_cond_pass = w_z | (w_n != w_v);
      4'hE: w_cond_pass = 1'b1;
      4'hF: w_cond_pass = 1'b0;
    endcase
  end

  // Raw decode, before condition gating
  logic [3:0] w_dec_cmd;
  logic       w_dec_mem_r;
  logic       w_dec_mem_w;
  logic       w_dec_wb_en;
  logic       w_dec_s_bit;
  logic       w_dec_b_en;
  logic       w_dec_imm;

  always_comb begin
    w_dec_cmd   = 4'b0000;
    w_dec_mem_r = 1'b0;
    w_dec_mem_w = 1'b0;
    w_dec_wb_en = 1'b0;
    w_dec_s_bit = 1'b0;
    w_dec_b_en  = 1'b0;
    w_dec_imm   = 1'b0;
    unique case (w_mode)
      2'b00: begin
        // Unlisted opcodes fall through to the all-zero NOP defaults
        unique case (w_opcode)
          4'b1101: begin w_dec_cmd = 4'b0001; w_dec_wb_en = 1'b1; end  // MOV
          4'b1111: begin w_dec_cmd = 4'b1001; w_dec_wb_en = 1'b1; end  // MVN
          4'b0100: begin w_dec_cmd = 4'b0010; w_dec_wb_en = 1'b1; end  // ADD
          4'b0101: begin w_dec_cmd = 4'b0011; w_dec_wb_en = 1'b1; end  // ADC
          4'b0010: begin w_dec_cmd = 4'b0100; w_dec_wb_en = 1'b1; end  // SUB
          4'b0110: begin w_dec_cmd = 4'b0101; w_dec_wb_en = 1'b1; end  // SBC
          4'b0000: begin w_dec_cmd = 4'b0110; w_dec_wb_en = 1'b1; end  // AND
          4'b1100: begin w_dec_cmd = 4'b0111; w_dec_wb_en = 1'b1; end  // ORR
          4'b0001: begin w_dec_cmd = 4'b1000; w_dec_wb_en = 1'b1; end  // EOR
          4'b1010: w_dec_cmd = 4'b0100;                                // CMP
          4'b1000: w_dec_cmd = 4'b0110;                                // TST
          default: ;
        endcase
        if (w_dec_cmd != 4'b0000) begin
          w_dec_imm   = w_i;
          // Compare/test exist only to set flags
          w_dec_s_bit = w_s | (w_opcode == 4'b1010) | (w_opcode == 4'b1000);
        end
      end
      2'b01: begin
        w_dec_cmd   = 4'b0010;
        w_dec_imm   = w_i;
        w_dec_mem_r = w_s;
        w_dec_wb_en = w_s;
        w_dec_mem_w = ~w_s;
      end
      2'b10: w_dec_b_en = 1'b1;
      2'b11: ;
    endcase
  end

  // Condition-gated decode result
  logic [3:0] w_cmd;
  logic       w_mem_r;
  logic       w_mem_w;
  logic       w_wb_en;
  logic       w_s_bit;
  logic       w_b_en;

  assign w_cmd   = w_cond_pass ? w_dec_cmd : 4'b0000;
  assign w_mem_r = w_cond_pass & w_dec_mem_r;
  assign w_mem_w = w_cond_pass & w_dec_mem_w;
  assign w_wb_en = w_cond_pass & w_dec_wb_en;
  assign w_s_bit = w_cond_pass & w_dec_s_bit;
  assign w_b_en  = w_cond_pass & w_dec_b_en;

  assign two_src = ((w_mode == 2'b00) & ~w_i) | ((w_mode == 2'b01) & ~w_s);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_status   <= 4'b0000;
      r_exe_cmd  <= 4'b0000;
      r_mem_r    <= 1'b0;
      r_mem_w    <= 1'b0;
      r_wb_en    <= 1'b0;
      r_s_bit    <= 1'b0;
      r_b_en     <= 1'b0;
      r_imm      <= 1'b0;
      r_dest     <= 4'b0000;
      r_shift_op <= 12'h000;
      r_simm24   <= 24'h000000;
      r_pc       <= 32'h0;
      r_val_rn   <= 32'h0;
      r_val_rm   <= 32'h0;
    end else begin
      // Flag register runs independently of the pipeline controls
      if (status_wr) begin
        r_status <= flags_in;
      end
      if (flush) begin
        r_exe_cmd  <= 4'b0000;
        r_mem_r    <= 1'b0;
        r_mem_w    <= 1'b0;
        r_wb_en    <= 1'b0;
        r_s_bit    <= 1'b0;
        r_b_en     <= 1'b0;
        r_imm      <= 1'b0;
        r_dest     <= 4'b0000;
        r_shift_op <= 12'h000;
        r_simm24   <= 24'h000000;
        r_pc       <= 32'h0;
        r_val_rn   <= 32'h0;
        r_val_rm   <= 32'h0;
      end else if (!freeze) begin
        // A bubble still carries fields and data; only control is killed
        r_exe_cmd  <= hazard ? 4'b0000 : w_cmd;
        r_mem_r    <= ~hazard & w_mem_r;
        r_mem_w    <= ~hazard & w_mem_w;
        r_wb_en    <= ~hazard & w_wb_en;
        r_s_bit    <= ~hazard & w_s_bit;
        r_b_en     <= ~hazard & w_b_en;
        r_imm      <= ~hazard & w_dec_imm;
        r_dest     <= instr[15:12];
        r_shift_op <= instr[11:0];
        r_simm24   <= instr[23:0];
        r_pc       <= pc_in;
        r_val_rn   <= val_rn;
        r_val_rm   <= val_rm;
      end
    end
  end

  assign status   = r_status;
  assign exe_cmd  = r_exe_cmd;
  assign mem_r    = r_mem_r;
  assign mem_w    = r_mem_w;
  assign wb_en    = r_wb_en;
  assign s_bit    = r_s_bit;
  assign b_en     = r_b_en;
  assign imm      = r_imm;
  assign dest     = r_dest;
  assign shift_op = r_shift_op;
  assign simm24   = r_simm24;
  assign pc_out   = r_pc;
  assign val_rn_o = r_val_rn;
  assign val_rm_o = r_val_rm;

endmodule

// File: tb/tb_id_exe_ctrl.sv
// Scoreboard bench for id_exe_ctrl: a driver applies directed then random
// stimulus on the falling edge and pushes the expected post-edge state from a
// behavioural model; a monitor pops and compares after every rising edge.
module tb_id_exe_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] instr, pc_in, val_rn, val_rm;
  logic        hazard, freeze, flush, status_wr;
  logic [3:0]  flags_in;
  logic [3:0]  exe_cmd;
  logic        mem_r, mem_w, wb_en, s_bit, b_en, imm;
  logic [3:0]  dest;
  logic [11:0] shift_op;
  logic [23:0] simm24;
  logic [31:0] pc_out, val_rn_o, val_rm_o;
  logic [3:0]  status;
  logic        two_src;

  id_exe_ctrl dut (
    .clk(clk), .rst(rst), .instr(instr), .pc_in(pc_in), .val_rn(val_rn), .val_rm(val_rm),
    .hazard(hazard), .freeze(freeze), .flush(flush), .status_wr(status_wr),
    .flags_in(flags_in), .exe_cmd(exe_cmd), .mem_r(mem_r), .mem_w(mem_w), .wb_en(wb_en),
    .s_bit(s_bit), .b_en(b_en), .imm(imm), .dest(dest), .shift_op(shift_op),
    .simm24(simm24), .pc_out(pc_out), .val_rn_o(val_rn_o), .val_rm_o(val_rm_o),
    .status(status), .two_src(two_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  exe_cmd;
    logic        mem_r, mem_w, wb_en, s_bit, b_en, imm;
    logic [3:0]  dest;
    logic [11:0] shift_op;
    logic [23:0] simm24;
    logic [31:0] pc, rn, rm;
  } out_t;

  typedef struct packed {
    out_t       regs;
    logic [3:0] status;
  } exp_t;

  typedef struct {
    logic [31:0] instr, pc, rn, rm;
    logic        rst, hz, fz, fl, sw;
    logic [3:0]  flags;
  } stim_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  // Model state: what the pipeline register and flags should currently hold
  out_t       m_regs = '0;
  logic [3:0] m_status = 4'b0000;

  function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] st);
    logic n, z, cy, v;
    {n, z, cy, v} = st;
    case (c)
      4'h0: return z;            4'h1: return !z;
      4'h2: return cy;           4'h3: return !cy;
      4'h4: return n;            4'h5: return !n;
      4'h6: return v;            4'h7: return !v;
      4'h8: return cy && !z;     4'h9: return !cy || z;
      4'hA: return n == v;       4'hB: return n != v;
      4'hC: return !z && n == v; 4'hD: return z || n != v;
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic out_t decode(input stim_t s, input logic [3:0] st);
    out_t o;
    logic [3:0] cmd;
    logic       writes;
    o = '0;
    o.dest = s.instr[15:12];
    o.shift_op = s.instr[11:0];
    o.simm24 = s.instr[23:0];
    o.pc = s.pc;
    o.rn = s.rn;
    o.rm = s.rm;
    if (s.instr[27:26] == 2'd0) begin
      writes = 1'b1;
      case (s.instr[24:21])
        4'd13: cmd = 1;  4'd15: cmd = 9;  4'd4: cmd = 2;  4'd5: cmd = 3;
        4'd2:  cmd = 4;  4'd6:  cmd = 5;  4'd0: cmd = 6;  4'd12: cmd = 7;
        4'd1:  cmd = 8;
        4'd10: begin cmd = 4; writes = 1'b0; end
        4'd8:  begin cmd = 6; writes = 1'b0; end
        default: cmd = 0;
      endcase
      if (cmd != 0) begin
        o.exe_cmd = cmd;
        o.wb_en = writes;
        o.s_bit = writes ? s.instr[20] : 1'b1;
        o.imm = s.instr[25];
      end
    end else if (s.instr[27:26] == 2'd1) begin
      o.exe_cmd = 2;
      o.imm = s.instr[25];
      if (s.instr[20]) begin o.mem_r = 1; o.wb_en = 1; end
      else o.mem_w = 1;
    end else if (s.instr[27:26] == 2'd2) begin
      o.b_en = 1;
    end
    if (!cond_holds(s.instr[31:28], st)) begin
      o.exe_cmd = 0; o.mem_r = 0; o.mem_w = 0; o.wb_en = 0; o.s_bit = 0; o.b_en = 0;
    end
    return o;
  endfunction

  task automatic drive(input stim_t s);
    out_t d;
    logic exp_two;
    @(negedge clk);
    instr = s.instr; pc_in = s.pc; val_rn = s.rn; val_rm = s.rm;
    rst = s.rst; hazard = s.hz; freeze = s.fz; flush = s.fl;
    status_wr = s.sw; flags_in = s.flags;
    #1;
    exp_two = (s.instr[27:26] == 2'd0 && !s.instr[25]) ||
              (s.instr[27:26] == 2'd1 && !s.instr[20]);
    n_checks++;
    if (two_src !== exp_two) begin
      n_fails++;
      $display("FAIL two_src instr=%h got %b want %b", s.instr, two_src, exp_two);
    end
    d = decode(s, m_status);
    if (s.rst || s.fl) m_regs = '0;
    else if (s.fz) m_regs = m_regs;
    else if (s.hz) begin
      m_regs = d;
      m_regs.exe_cmd = 0; m_regs.mem_r = 0; m_regs.mem_w = 0; m_regs.wb_en = 0;
      m_regs.s_bit = 0; m_regs.b_en = 0; m_regs.imm = 0;
    end else m_regs = d;
    if (s.rst) m_status = 4'b0000;
    else if (s.sw) m_status = s.flags;
    sb_q.push_back('{regs: m_regs, status: m_status});
  endtask

  // Monitor: one expected entry per rising edge once stimulus has started
  initial begin
    exp_t e;
    out_t got;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        got = {exe_cmd, mem_r, mem_w, wb_en, s_bit, b_en, imm, dest, shift_op, simm24,
               pc_out, val_rn_o, val_rm_o};
        n_checks++;
        if (got !== e.regs) begin
          n_fails++;
          $display("FAIL regs t=%0t got cmd=%h ctl=%b pc=%h all=%h want cmd=%h ctl=%b pc=%h all=%h",
                   $time, got.exe_cmd, {got.mem_r, got.mem_w, got.wb_en, got.s_bit, got.b_en,
                   got.imm}, got.pc, got, e.regs.exe_cmd, {e.regs.mem_r, e.regs.mem_w,
                   e.regs.wb_en, e.regs.s_bit, e.regs.b_en, e.regs.imm}, e.regs.pc, e.regs);
        end
        n_checks++;
        if (status !== e.status) begin
          n_fails++;
          $display("FAIL status t=%0t got %b want %b", $time, status, e.status);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic stim_t mk(input logic [31:0] ins, input logic [31:0] pc,
                               input logic r, input logic hz, input logic fz, input logic fl,
                               input logic sw, input logic [3:0] fg);
    stim_t s;
    s.instr = ins; s.pc = pc; s.rn = 32'h1111_0000 + pc; s.rm = 32'h2222_0000 + pc;
    s.rst = r; s.hz = hz; s.fz = fz; s.fl = fl; s.sw = sw; s.flags = fg;
    return s;
  endfunction

  initial begin
    stim_t dir[$];
    stim_t s;
    rst = 1'b1; instr = '0; pc_in = '0; val_rn = '0; val_rm = '0;
    hazard = 0; freeze = 0; flush = 0; status_wr = 0; flags_in = '0;

    //          instr         pc     rst hz fz fl sw flags
    dir.push_back(mk(32'hE0821003, 32'h04, 1, 0, 0, 0, 0, 4'h0)); // reset with ADD
    dir.push_back(mk(32'hE0821003, 32'h08, 0, 0, 0, 0, 0, 4'h0)); // ADD
    dir.push_back(mk(32'h03A01005, 32'h0C, 0, 0, 0, 0, 1, 4'h4)); // MOVEQ, old Z=0
    dir.push_back(mk(32'h03A01005, 32'h10, 0, 0, 0, 0, 0, 4'h0)); // MOVEQ, Z=1
    dir.push_back(mk(32'hE1510002, 32'h14, 0, 0, 0, 0, 0, 4'h0)); // CMP
    dir.push_back(mk(32'hE5910000, 32'h18, 0, 0, 0, 0, 0, 4'h0)); // LDR
    dir.push_back(mk(32'hE5810000, 32'h1C, 0, 0, 0, 0, 0, 4'h0)); // STR
    dir.push_back(mk(32'hE0821003, 32'h100, 0, 0, 0, 0, 0, 4'h0)); // ADD
    dir.push_back(mk(32'hE1510002, 32'h200, 0, 0, 1, 0, 0, 4'h0)); // freeze
    dir.push_back(mk(32'hE1510002, 32'h204, 0, 1, 1, 0, 1, 4'h9)); // freeze beats hazard
    dir.push_back(mk(32'hE1510002, 32'h300, 0, 1, 0, 0, 0, 4'h0)); // bubble
    dir.push_back(mk(32'hEA000004, 32'h304, 0, 0, 1, 1, 0, 4'h0)); // flush beats freeze
    dir.push_back(mk(32'hF0821003, 32'h308, 0, 0, 0, 0, 0, 4'h0)); // never
    dir.push_back(mk(32'hEA000004, 32'h30C, 0, 0, 0, 0, 0, 4'h0)); // branch
    foreach (dir[i]) drive(dir[i]);

    for (int i = 0; i < 500; i++) begin
      s.instr = $urandom;
      if ($urandom_range(0, 1) == 0) s.instr[31:28] = 4'hE;
      s.pc = $urandom; s.rn = $urandom; s.rm = $urandom;
      s.rst = ($urandom_range(0, 49) == 0);
      s.fl  = ($urandom_range(0, 11) == 0);
      s.fz  = ($urandom_range(0, 7) == 0);
      s.hz  = ($urandom_range(0, 7) == 0);
      s.sw  = ($urandom_range(0, 3) == 0);
      s.flags = 4'($urandom);
      drive(s);
    end

    @(posedge clk);
    #3;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fails++;
      $display("FAIL drain: got %0d entries left want 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/id_exe_ctrl.md
# id_exe_ctrl

Decode-side producer of the ALU command interface. It decodes a 32-bit ARM data-processing, memory or branch instruction into a 4-bit `exe_cmd` and stage control bits. It gates the instruction on its condition field against an internal NZCV status register, and registers the result into the ID/EXE pipeline register with bubble, flush and freeze support. It sits between the register-file/decode stage and the EXE stage that feeds the ALU, and it takes back the ALU flags to update the status register.

## Interface
Parameters:
- none

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `instr` in 32: instruction in ID.
- `pc_in` in 32: PC of instruction in ID.
- `val_rn`, `val_rm` in 32 each: register-file read data.
- `hazard` in 1: insert bubble this cycle.
- `freeze` in 1: hold pipeline register.
- `flush` in 1: branch taken in EXE; kill ID/EXE.
- `status_wr` in 1: EXE instruction has S=1 and is valid.
- `flags_in` in 4: {N,Z,C,V} from ALU/EXE.
- `exe_cmd` out 4: registered ALU command.
- `mem_r`, `mem_w`, `wb_en`, `s_bit`, `b_en`, `imm` out 1 each: registered control.
- `dest` out 4, `shift_op` out 12, `simm24` out 24: registered fields.
- `pc_out`, `val_rn_o`, `val_rm_o` out 32: registered pass-through.
- `status` out 4: current NZCV register.
- `two_src` out 1: combinational, instruction uses Rm (`~I` for data-processing, or STR).

## Operation
- Fields: cond [31:28], mode [27:26], I [25], opcode [24:21], S/L [20], Rn [19:16], Rd [15:12], shift_op [11:0], simm24 [23:0].
- Mode 00, data-processing. opcode→exe_cmd:
  - MOV 1101→0001; MVN 1111→1001 (`wb_en`=1)
  - ADD 0100→0010; ADC 0101→0011
  - SUB 0010→0100; SBC 0110→0101
  - AND 0000→0110; ORR 1100→0111; EOR 0001→1000 (all `wb_en`=1)
  - CMP 1010→0100; TST 1000→0110 (`wb_en`=0)
  - Other opcodes: NOP, with all control bits 0 and exe_cmd 0000.
  - `s_bit`=S. CMP/TST force `s_bit`=1.
- Mode 01, memory: exe_cmd 0010. L=1 gives LDR (`mem_r`=1, `wb_en`=1). L=0 gives STR (`mem_w`=1). `s_bit`=0.
- Mode 10, branch: `b_en`=1, exe_cmd 0000, all other control bits 0.
- Mode 11: NOP.
- Condition check uses the registered `status`, not `flags_in`:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V
  - GT !Z&(N==V); LE Z|(N!=V); AL 1; 1111 0
  - Failed condition zeroes `mem_r`, `mem_w`, `wb_en`, `s_bit`, `b_en` and sets exe_cmd to 0000.
- Pipeline register update priority, per rising edge:
  1. `rst`: all registered outputs 0.
  2. `flush`: all registered outputs 0.
  3. `freeze`: hold all.
  4. `hazard`: control bits and exe_cmd 0; fields and data still load.
  5. Otherwise: load the decode result.
- Status register:
  - Loads `flags_in` when `status_wr`=1.
  - `rst` clears it to 0000.
  - It is not affected by `freeze`, `flush` or `hazard`.

## Timing
- Decode-to-output latency: 1 cycle. `two_src` is combinational, 0 cycles.
- Reset: every registered output 0 and `status`=0000 after the first edge with `rst`=1.
- Simultaneous `status_wr` and a conditional instruction in ID: the condition uses the old flags. The new flags are visible to the instruction in ID from the next cycle.
- `flush` together with `freeze`: flush wins.
- `hazard` together with `freeze`: freeze wins (hold).
- Reset asserted mid-stream discards the in-flight instruction. There is no partial state.

## Test plan
- Reset: drive `rst`=1 for 1 cycle with instr 0xE0821003 (ADD) → all outputs 0, `status`=0000.
- ADD: instr 0xE0821003, `status` 0000 → next cycle exe_cmd=0010, `wb_en`=1, `dest`=1, `imm`=0, `two_src`=1 combinationally.
- Conditional:
  1. Cycle 1: `status_wr`=1 with `flags_in`=0100 (Z).
  2. Cycle 1, same edge: instr 0x0... MOVEQ 0x03A01005 → result registered as NOP (old Z=0).
  3. Following cycle: same instr → exe_cmd=0001, `wb_en`=1.
- CMP/LDR/STR:
  - 0xE1510002 → exe_cmd=0100, `s_bit`=1, `wb_en`=0.
  - 0xE5910000 → exe_cmd=0010, `mem_r`=1, `wb_en`=1.
  - 0xE5810000 → `mem_w`=1, `two_src`=1.
- Hazard/freeze: load ADD, then `freeze`=1 for 2 cycles with a new instr → outputs unchanged. Then `hazard`=1 → control bits 0, `pc_out` updated.
- Flush priority: `flush`=1 and `freeze`=1 with branch 0xEA000004 → all registered outputs 0, `b_en`=0.
